load_store_unit: RTL and testbench

//  Memory-side responder to the control unit's load/store handshake (cyc/ack/data_valid, memory_operation).

---
 rtl/global_pkg.sv | 46 ++++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
// global_pkg: shared types and constants for the core datapath and load/store unit.
// Rev 1.0
`default_nettype none

package global_pkg;

  typedef enum logic [1:0] {
    MEM_NONE   = 2'd0,
    LOAD_DATA  = 2'd1,
    STORE_DATA = 2'd2
  } memory_operation_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic funct3_legal(input memory_operation_t op, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (op == LOAD_DATA) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane selects, write-data replication and load extraction/extension.
// Rev 1.0
`default_nettype none

module lsu_lane_align
  import global_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    w_byte      = rdata_i[{offset_i, 3'b000} +: 8];
    w_half      = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    // funct3[2] distinguishes the unsigned load variants
    w_signed    = ~funct3_i[2];
    sel_o       = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        sel_o       = 4'b0001 << offset_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{w_byte[7] & w_signed}}, w_byte};
      end
      2'b01: begin
        sel_o       = 4'b0011 << offset_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = {{16{w_half[15] & w_signed}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: latches one control-unit request and runs a single Wishbone classic transfer.
// Rev 1.0
`default_nettype none

module load_store_unit
  import global_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  output logic              ack,
  output logic              data_valid,
  input  memory_operation_t memory_operation,
  input  logic [2:0]        funct3,
  input  logic [31:0]       address,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              access_fault,
  output logic [31:0]       fault_addr,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [31:0]       wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int               c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t          state_q;
  memory_operation_t   op_q;
  logic [2:0]          funct3_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [c_CNT_W-1:0]  cnt_q;
  logic                ack_q;
  logic                data_valid_q;
  logic [31:0]         load_data_q;
  logic                misaligned_q;
  logic                access_fault_q;
  logic [31:0]         fault_addr_q;
  logic                wb_cyc_q;

  logic [3:0]          w_sel;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata;

  lsu_lane_align u_lane_align (
    .funct3_i     (funct3_q),
    .offset_i     (addr_q[1:0]),
    .store_data_i (wdata_q),
    .rdata_i      (wb_dat_i),
    .sel_o        (w_sel),
    .wdata_o      (w_wdata),
    .load_data_o  (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= LSU_IDLE;
      op_q           <= MEM_NONE;
      funct3_q       <= 3'b000;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      cnt_q          <= '0;
      ack_q          <= 1'b0;
      data_valid_q   <= 1'b0;
      load_data_q    <= 32'h0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      fault_addr_q   <= 32'h0;
      wb_cyc_q       <= 1'b0;
    end else begin
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (cyc && (memory_operation != MEM_NONE)) begin
            op_q         <= memory_operation;
            funct3_q     <= funct3;
            addr_q       <= address;
            wdata_q      <= store_data;
            data_valid_q <= 1'b0;
            load_data_q  <= 32'h0;
            cnt_q        <= '0;
            if (!funct3_legal(memory_operation, funct3)) begin
              access_fault_q <= 1'b1;
              fault_addr_q   <= address;
              state_q        <= LSU_RESP;
            end else if (is_misaligned(funct3, address[1:0])) begin
              misaligned_q <= 1'b1;
              fault_addr_q <= address;
              state_q      <= LSU_RESP;
            end else begin
              wb_cyc_q <= 1'b1;
              state_q  <= LSU_BUS;
            end
          end
        end
        LSU_BUS: begin
          // err outranks ack; an ack on the final timeout cycle still completes normally
          if (wb_err_i) begin
            wb_cyc_q       <= 1'b0;
            access_fault_q <= 1'b1;
            fault_addr_q   <= addr_q;
            state_q        <= LSU_RESP;
          end else if (wb_ack_i) begin
            wb_cyc_q <= 1'b0;
            if (op_q == LOAD_DATA) begin
              load_data_q <= w_rdata;
            end
            state_q <= LSU_RESP;
          end else if (cnt_q == c_CNT_LAST) begin
            wb_cyc_q       <= 1'b0;
            access_fault_q <= 1'b1;
            fault_addr_q   <= addr_q;
            state_q        <= LSU_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LSU_RESP: begin
          ack_q <= cyc;
          if (op_q == LOAD_DATA) begin
            data_valid_q <= 1'b1;
          end
          if (!cyc) begin
            state_q <= LSU_IDLE;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign ack          = ack_q;
  assign data_valid   = data_valid_q;
  assign load_data    = load_data_q;
  assign misaligned   = misaligned_q;
  assign access_fault = access_fault_q;
  assign fault_addr   = fault_addr_q;

  assign wb_cyc_o = wb_cyc_q;
  assign wb_stb_o = wb_cyc_q;
  assign wb_we_o  = wb_cyc_q & (op_q == STORE_DATA);
  assign wb_adr_o = wb_cyc_q ? {addr_q[31:2], 2'b00} : 32'h0;
  assign wb_sel_o = wb_cyc_q ? w_sel : 4'b0000;
  assign wb_dat_o = (wb_cyc_q && (op_q == STORE_DATA)) ? w_wdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Rev 1.0
`default_nettype none

module tb_load_store_unit;
  import global_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cyc = 1'b0;
  logic              ack;
  logic              data_valid;
  memory_operation_t memory_operation = MEM_NONE;
  logic [2:0]        funct3 = 3'b000;
  logic [31:0]       address = 32'h0;
  logic [31:0]       store_data = 32'h0;
  logic [31:0]       load_data;
  logic              misaligned;
  logic              access_fault;
  logic [31:0]       fault_addr;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [31:0]       wb_adr_o;
  logic [3:0]        wb_sel_o;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i = 32'h0;
  logic              wb_ack_i = 1'b0;
  logic              wb_err_i = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        obs_bus, obs_we, obs_mis, obs_fault, obs_ack, obs_dv, obs_ack_after, obs_stable;
  logic [3:0]  obs_sel;
  logic [31:0] obs_adr, obs_dat;
  int          obs_bus_cycles, obs_lat;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cyc              (cyc),
    .ack              (ack),
    .data_valid       (data_valid),
    .memory_operation (memory_operation),
    .funct3           (funct3),
    .address          (address),
    .store_data       (store_data),
    .load_data        (load_data),
    .misaligned       (misaligned),
    .access_fault     (access_fault),
    .fault_addr       (fault_addr),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_adr_o         (wb_adr_o),
    .wb_sel_o         (wb_sel_o),
    .wb_dat_o         (wb_dat_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack_i         (wb_ack_i),
    .wb_err_i         (wb_err_i)
  );

  always #5 clk = ~clk;

  // mode 0: slave acks after 'waits' cycles, 1: slave errors, 2: slave silent
  task automatic run_access(input memory_operation_t op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input int waits, input logic [31:0] rdat, input int mode);
    obs_bus = 0; obs_we = 0; obs_mis = 0; obs_fault = 0; obs_ack = 0; obs_dv = 0;
    obs_stable = 1; obs_sel = 4'h0; obs_adr = 32'h0; obs_dat = 32'h0;
    obs_bus_cycles = 0; obs_lat = 0;
    @(negedge clk);
    cyc = 1'b1; memory_operation = op; funct3 = f3; address = addr; store_data = sd;
    for (int t = 0; t < 64 && !obs_ack; t++) begin
      @(negedge clk);
      obs_lat = t + 1;
      if (misaligned) obs_mis = 1;
      if (access_fault) obs_fault = 1;
      if (ack) begin
        obs_ack = 1;
        obs_dv  = data_valid;
      end
      if (wb_cyc_o) begin
        if (wb_stb_o !== 1'b1) obs_stable = 0;
        if (!obs_bus) begin
          obs_sel = wb_sel_o; obs_adr = wb_adr_o; obs_we = wb_we_o; obs_dat = wb_dat_o;
        end else if (wb_sel_o !== obs_sel || wb_adr_o !== obs_adr ||
                     wb_we_o !== obs_we || wb_dat_o !== obs_dat) begin
          obs_stable = 0;
        end
        obs_bus = 1;
        obs_bus_cycles++;
        if (mode != 2 && obs_bus_cycles > waits) begin
          if (mode == 0) begin wb_ack_i = 1'b1; wb_dat_i = rdat; end
          else wb_err_i = 1'b1;
        end
      end else begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end
    end
    checks++;
    if (obs_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_arrival addr=%h: ack got %b required 1 within 64 cycles", addr, obs_ack);
    end
    cyc = 1'b0; memory_operation = MEM_NONE; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(negedge clk);
    obs_ack_after = ack;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({ack, data_valid, misaligned, access_fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b required 0000", {ack, data_valid, misaligned, access_fault}); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'h0) begin errors++; $display("FAIL reset_bus: got %b required 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
    checks++; if (load_data !== 32'h0 || fault_addr !== 32'h0) begin errors++; $display("FAIL reset_data: load_data %h fault_addr %h required 0", load_data, fault_addr); end
    rst = 1'b1;
  endtask

  task automatic test_lw_wait();
    run_access(LOAD_DATA, F3_W, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0);
    checks++; if (obs_sel !== 4'b1111) begin errors++; $display("FAIL lw_sel: got %b required 1111", obs_sel); end
    checks++; if (obs_adr !== 32'h100 || obs_we !== 1'b0) begin errors++; $display("FAIL lw_adr_we: got %h/%b required 00000100/0", obs_adr, obs_we); end
    checks++; if (obs_bus_cycles !== 3) begin errors++; $display("FAIL lw_bus_cycles: got %0d required 3", obs_bus_cycles); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL lw_bus_stable: got %b required 1", obs_stable); end
    checks++; if (obs_dv !== 1'b1) begin errors++; $display("FAIL lw_dv_with_ack: got %b required 1", obs_dv); end
    checks++; if (load_data !== 32'hDEADBEEF || data_valid !== 1'b1) begin errors++; $display("FAIL lw_data: got %h dv %b required deadbeef dv 1", load_data, data_valid); end
    checks++; if (obs_ack_after !== 1'b0) begin errors++; $display("FAIL lw_ack_drop: got %b required 0", obs_ack_after); end
  endtask

  task automatic test_byte_loads();
    run_access(LOAD_DATA, F3_B, 32'h203, 32'h0, 0, 32'h80112233, 0);
    checks++; if (obs_sel !== 4'b1000 || obs_adr !== 32'h200) begin errors++; $display("FAIL lb_sel_adr: got %b/%h required 1000/00000200", obs_sel, obs_adr); end
    checks++; if (load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", load_data); end
    run_access(LOAD_DATA, F3_BU, 32'h203, 32'h0, 0, 32'h80112233, 0);
    checks++; if (load_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h required 00000080", load_data); end
  endtask

  task automatic test_half_loads_latency();
    run_access(LOAD_DATA, F3_W, 32'h400, 32'h0, 0, 32'h12345678, 0);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL zero_wait_latency: got %0d required 3", obs_lat); end
    checks++; if (load_data !== 32'h12345678) begin errors++; $display("FAIL lw0_data: got %h required 12345678", load_data); end
    run_access(LOAD_DATA, F3_H, 32'h502, 32'h0, 0, 32'h80011234, 0);
    checks++; if (obs_sel !== 4'b1100 || load_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_hi: sel %b data %h required 1100 ffff8001", obs_sel, load_data); end
    run_access(LOAD_DATA, F3_HU, 32'h500, 32'h0, 0, 32'h1234F00D, 0);
    checks++; if (obs_sel !== 4'b0011 || load_data !== 32'h0000F00D) begin errors++; $display("FAIL lhu_lo: sel %b data %h required 0011 0000f00d", obs_sel, load_data); end
  endtask

  task automatic test_stores();
    run_access(STORE_DATA, F3_H, 32'h302, 32'h0000ABCD, 0, 32'h0, 0);
    checks++; if (obs_we !== 1'b1 || obs_sel !== 4'b1100) begin errors++; $display("FAIL sh_we_sel: got %b/%b required 1/1100", obs_we, obs_sel); end
    checks++; if (obs_dat !== 32'hABCDABCD || obs_adr !== 32'h300) begin errors++; $display("FAIL sh_dat_adr: got %h/%h required abcdabcd/00000300", obs_dat, obs_adr); end
    checks++; if (obs_dv !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL sh_no_dv: got %b/%b required 0/0", obs_dv, data_valid); end
    run_access(STORE_DATA, F3_B, 32'h601, 32'h1234565A, 1, 32'h0, 0);
    checks++; if (obs_sel !== 4'b0010 || obs_dat !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_sel_dat: got %b/%h required 0010/5a5a5a5a", obs_sel, obs_dat); end
  endtask

  task automatic test_misaligned();
    run_access(LOAD_DATA, F3_W, 32'h101, 32'h0, 0, 32'hFFFFFFFF, 0);
    checks++; if (obs_mis !== 1'b1 || obs_fault !== 1'b0) begin errors++; $display("FAIL mis_pulse: mis %b fault %b required 1/0", obs_mis, obs_fault); end
    checks++; if (obs_bus !== 1'b0) begin errors++; $display("FAIL mis_no_bus: got %b required 0", obs_bus); end
    checks++; if (fault_addr !== 32'h101) begin errors++; $display("FAIL mis_fault_addr: got %h required 00000101", fault_addr); end
    checks++; if (obs_dv !== 1'b1 || load_data !== 32'h0) begin errors++; $display("FAIL mis_dv_data: dv %b data %h required 1/0", obs_dv, load_data); end
    run_access(STORE_DATA, F3_H, 32'h333, 32'h1, 0, 32'h0, 0);
    checks++; if (obs_mis !== 1'b1 || obs_bus !== 1'b0) begin errors++; $display("FAIL sh_mis: mis %b bus %b required 1/0", obs_mis, obs_bus); end
  endtask

  task automatic test_illegal_funct3();
    run_access(LOAD_DATA, 3'b011, 32'h700, 32'h0, 0, 32'h0, 0);
    checks++; if (obs_fault !== 1'b1 || obs_bus !== 1'b0) begin errors++; $display("FAIL ill_load: fault %b bus %b required 1/0", obs_fault, obs_bus); end
    checks++; if (fault_addr !== 32'h700) begin errors++; $display("FAIL ill_load_addr: got %h required 00000700", fault_addr); end
    run_access(STORE_DATA, F3_BU, 32'h704, 32'h0, 0, 32'h0, 0);
    checks++; if (obs_fault !== 1'b1 || obs_bus !== 1'b0 || obs_mis !== 1'b0) begin errors++; $display("FAIL ill_store: fault %b bus %b mis %b required 1/0/0", obs_fault, obs_bus, obs_mis); end
  endtask

  task automatic test_timeout_and_err();
    run_access(LOAD_DATA, F3_W, 32'h800, 32'h0, 0, 32'h0, 2);
    checks++; if (obs_fault !== 1'b1 || obs_bus_cycles !== 8) begin errors++; $display("FAIL timeout: fault %b cycles %0d required 1/8", obs_fault, obs_bus_cycles); end
    checks++; if (fault_addr !== 32'h800 || load_data !== 32'h0 || data_valid !== 1'b1) begin errors++; $display("FAIL timeout_state: fa %h data %h dv %b required 00000800/0/1", fault_addr, load_data, data_valid); end
    run_access(STORE_DATA, F3_W, 32'h900, 32'h11223344, 1, 32'h0, 1);
    checks++; if (obs_fault !== 1'b1 || obs_ack !== 1'b1 || obs_bus_cycles !== 2) begin errors++; $display("FAIL store_err: fault %b ack %b cycles %0d required 1/1/2", obs_fault, obs_ack, obs_bus_cycles); end
    checks++; if (fault_addr !== 32'h900 || obs_dat !== 32'h11223344) begin errors++; $display("FAIL store_err_addr: fa %h dat %h required 00000900/11223344", fault_addr, obs_dat); end
  endtask

  task automatic test_reset_mid_bus();
    bit seen;
    seen = 0;
    @(negedge clk);
    cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = F3_W; address = 32'hA00;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (wb_cyc_o) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_bus_start: wb_cyc_o got 0 required 1"); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, ack} !== 3'b000) begin errors++; $display("FAIL rst_mid_bus: cyc/stb/ack got %b required 000", {wb_cyc_o, wb_stb_o, ack}); end
    cyc = 1'b0; memory_operation = MEM_NONE;
    @(negedge clk);
    rst = 1'b1;
    run_access(LOAD_DATA, F3_W, 32'hA04, 32'h0, 1, 32'hCAFEF00D, 0);
    checks++; if (load_data !== 32'hCAFEF00D || obs_adr !== 32'hA04) begin errors++; $display("FAIL post_reset_lw: data %h adr %h required cafef00d/00000a04", load_data, obs_adr); end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_byte_loads();
    test_half_loads_latency();
    test_stores();
    test_misaligned();
    test_illegal_funct3();
    test_timeout_and_err();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
